pulp_icache_fetch_arb: RTL

PULP_ICACHE_FETCH_ARB -- requirements
Module: pulp_icache_fetch_arb

---
 rtl/pulp_icache_fetch_arb.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/pulp_icache_fetch_arb.sv
// pulp_icache_fetch_arb
// Shares one in-order instruction-cache fetch port between NumReq requesters.
// Round-robin arbitration with the selection held stable while the cache
// stalls the request; a small ID FIFO routes in-order responses back to
// the requester that issued each fetch.
// Optional feature: define PULP_ICACHE_FETCH_ARB_STALL_CNT_EN to build the
// per-requester 16-bit saturating stall counters; otherwise stall_cnt_o is 0.
module pulp_icache_fetch_arb #(
  parameter int unsigned NumReq         = 2,
  parameter int unsigned FetchAddrWidth = 32,
  parameter int unsigned FetchDataWidth = 32,
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic                                     clk_i,
  input  logic                                     rst_i,
  input  logic [NumReq-1:0]                        req_i,
  input  logic [NumReq-1:0][FetchAddrWidth-1:0]    addr_i,
  output logic [NumReq-1:0]                        gnt_o,
  output logic [NumReq-1:0]                        rvalid_o,
  output logic [NumReq-1:0][FetchDataWidth-1:0]    rdata_o,
  output logic [NumReq-1:0]                        rerror_o,
  output logic                                     fetch_req_o,
  output logic [FetchAddrWidth-1:0]                fetch_addr_o,
  input  logic                                     fetch_gnt_i,
  input  logic                                     fetch_rvalid_i,
  input  logic [FetchDataWidth-1:0]                fetch_rdata_i,
  input  logic                                     fetch_rerror_i,
  output logic [NumReq-1:0][15:0]                  stall_cnt_o,
  output logic                                     rsp_err_o
);

  localparam int unsigned IdxW = $clog2(NumReq);
  localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

  // Selection is either free (round-robin each cycle) or held on a requester
  // whose request is waiting for the cache grant.
  typedef enum logic {
    ARB_FREE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

  arb_state_t            state_reg, state_next;
  logic [IdxW-1:0]       last_reg, last_next;
  logic [IdxW-1:0]       lock_idx_reg, lock_idx_next;
  logic [IdxW-1:0]       rr_idx;
  logic [IdxW-1:0]       cand;
  logic                  rr_found;
  logic [IdxW-1:0]       sel_idx;

  logic [IdxW-1:0]       id_mem_reg [MaxOutstanding];
  logic [PtrW-1:0]       wr_ptr_reg, rd_ptr_reg;
  logic [CntW-1:0]       count_reg;
  logic                  fifo_empty, fifo_full, can_accept;
  logic                  push, pop, unexpected;
  logic [IdxW-1:0]       head_idx;
  logic                  rsp_err_reg;

  // Wrap-around increment for the FIFO pointers.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    if (p == PtrW'(MaxOutstanding - 1)) begin
      return '0;
    end
    return p + 1'b1;
  endfunction

  // FIFO status; a full FIFO still accepts when a response frees a slot now.
  assign fifo_empty = (count_reg == '0);
  assign fifo_full  = (count_reg == CntW'(MaxOutstanding));
  assign can_accept = !fifo_full || fetch_rvalid_i;
  assign push       = fetch_req_o & fetch_gnt_i;
  assign pop        = fetch_rvalid_i & !fifo_empty;
  assign unexpected = fetch_rvalid_i & fifo_empty;
  assign head_idx   = id_mem_reg[rd_ptr_reg];

  // Round-robin search starting at the requester after the last winner.
  always_comb begin
    rr_idx   = last_reg;
    rr_found = 1'b0;
    cand     = '0;
    for (int k = 1; k <= int'(NumReq); k++) begin
      cand = IdxW'((int'(last_reg) + k) % int'(NumReq));
      if (!rr_found && req_i[cand]) begin
        rr_found = 1'b1;
        rr_idx   = cand;
      end
    end
  end

  // Arbiter next-state and fetch request: hold the selection until granted.
  always_comb begin
    state_next    = state_reg;
    lock_idx_next = lock_idx_reg;
    last_next     = last_reg;
    sel_idx       = rr_idx;
    fetch_req_o   = 1'b0;
    case (state_reg)
      ARB_FREE: begin
        sel_idx     = rr_idx;
        fetch_req_o = rr_found & can_accept;
      end
      ARB_LOCKED: begin
        sel_idx     = lock_idx_reg;
        fetch_req_o = req_i[lock_idx_reg] & can_accept;
      end
      default: begin
        sel_idx     = rr_idx;
        fetch_req_o = 1'b0;
      end
    endcase
    if (fetch_req_o && !fetch_gnt_i) begin
      state_next    = ARB_LOCKED;
      lock_idx_next = sel_idx;
    end else begin
      state_next = ARB_FREE;
    end
    if (fetch_req_o && fetch_gnt_i) begin
      last_next = sel_idx;
    end
  end

  assign fetch_addr_o = addr_i[sel_idx];

  // Arbiter state register; pointer restarts so requester 0 wins first.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg    <= ARB_FREE;
      last_reg     <= IdxW'(NumReq - 1);
      lock_idx_reg <= '0;
    end else begin
      state_reg    <= state_next;
      last_reg     <= last_next;
      lock_idx_reg <= lock_idx_next;
    end
  end

  // ID FIFO storage; contents are only meaningful while counted as occupied.
  always_ff @(posedge clk_i) begin
    if (push) begin
      id_mem_reg[wr_ptr_reg] <= sel_idx;
    end
  end

  // ID FIFO pointers and occupancy; push and pop together leave it unchanged.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      end
      if (pop) begin
        rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      end
      if (push && !pop) begin
        count_reg <= count_reg + 1'b1;
      end else if (pop && !push) begin
        count_reg <= count_reg - 1'b1;
      end
    end
  end

  // Sticky flag for a response arriving with nothing outstanding.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rsp_err_reg <= 1'b0;
    end else if (unexpected) begin
      rsp_err_reg <= 1'b1;
    end
  end

  assign rsp_err_o = rsp_err_reg;

  // Per-requester grant and response routing.
  for (genvar gi = 0; gi < int'(NumReq); gi++) begin : g_lane
    assign gnt_o[gi]    = push && (sel_idx == IdxW'(gi));
    assign rvalid_o[gi] = pop && (head_idx == IdxW'(gi));
    assign rerror_o[gi] = pop && (head_idx == IdxW'(gi)) && fetch_rerror_i;
    assign rdata_o[gi]  = fetch_rdata_i;
  end

`ifdef PULP_ICACHE_FETCH_ARB_STALL_CNT_EN
  for (genvar gi = 0; gi < int'(NumReq); gi++) begin : g_stall
    logic [15:0] cnt_reg;

    // Count cycles spent requesting without a grant, saturating at all-ones.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        cnt_reg <= '0;
      end else if (req_i[gi] && !gnt_o[gi] && (cnt_reg != 16'hFFFF)) begin
        cnt_reg <= cnt_reg + 16'd1;
      end
    end

    assign stall_cnt_o[gi] = cnt_reg;
  end
`else
  assign stall_cnt_o = '0;
`endif

endmodule
